// File: rtl/b2bd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
// Latency: none (types, constants and an elaboration-time helper only).
// Backpressure: not applicable.
// Contents: state_t FSM encoding, add-3 constants, digits_min() legality helper.
package b2bd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Smallest digit count whose decimal range covers 2^bw - 1.
    // 64-bit arithmetic, so valid for bw up to 63.
    function automatic int digits_min(input int bw);
        longint unsigned max_val;
        longint unsigned pow10;
        int              d;
        max_val = (64'd1 << bw) - 64'd1;
        pow10   = 64'd1;
        d       = 0;
        while (pow10 <= max_val) begin
            pow10 = pow10 * 64'd10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/b2bd_seq_if.sv
// Handshake/result bundle between a requester and b2bd_seq.
// Latency: none (wires only).
// Backpressure: requester may raise start any time; only taken while ready=1.
// Signals: start, bc (request); ready, busy, done, bdc and, with
// B2BD_BLANK_EN defined, blank (response). master = requester, slave = converter.
interface b2bd_seq_if #(
    parameter int BW     = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BW-1:0]         bc;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bdc;
`ifdef B2BD_BLANK_EN
    logic [DIGITS-1:0]     blank;

    modport master (output start, bc, input ready, busy, done, bdc, blank);
    modport slave  (input start, bc, output ready, busy, done, bdc, blank);
`else
    modport master (output start, bc, input ready, busy, done, bdc);
    modport slave  (input start, bc, output ready, busy, done, bdc);
`endif
endinterface

// File: rtl/b2bd_dig_adj.sv
// Double-dabble digit correction: a BCD digit >= 5 gets +3 before the shift.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: digit (4-bit BCD digit), adj (corrected digit).
module b2bd_dig_adj
    import b2bd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj
);
    // A valid digit is <= 9, so the corrected value is <= 12 and never
    // needs a carry into the next digit.
    assign adj = (digit >= BCD_ADJ_THRESH) ? (digit + BCD_ADJ_ADD) : digit;
endmodule

// File: rtl/b2bd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: start taken at edge N -> done pulse and new bdc after edge N+BW+1;
//          one conversion per BW+2 cycles.
// Backpressure: start is honoured only while ready=1; otherwise ignored, not queued.
// Ports: clk, rst (sync, active-high); bus (slave): start, bc -> ready, busy,
// done, bdc. Build macro B2BD_BLANK_EN adds bus.blank, a registered
// leading-zero mask (blank[0] always 0).
module b2bd_seq
    import b2bd_pkg::*;
#(
    parameter int BW     = 8,
    parameter int DIGITS = 3
)(
    input  logic       clk,
    input  logic       rst,
    b2bd_seq_if.slave  bus
);
    localparam int CW = $clog2(BW);
    localparam int SW = 4 * DIGITS;

    generate
        if (BW < 4) begin : g_bw_chk
            $error("b2bd_seq: BW must be at least 4");
        end
        if (DIGITS < digits_min(BW)) begin : g_digits_chk
            $error("b2bd_seq: DIGITS too small to hold 2^BW-1");
        end
    endgenerate

    state_t          state;
    logic [BW-1:0]   bin;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   adj;
    logic [CW-1:0]   cnt;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            b2bd_dig_adj u_adj (
                .digit (scratch[4*g +: 4]),
                .adj   (adj[4*g +: 4])
            );
        end
    endgenerate

`ifdef B2BD_BLANK_EN
    // blank[k] is set when digit k and every digit above it are zero.
    logic [DIGITS-1:0] blank_nxt;
    logic              hi_zero;
    always_comb begin
        blank_nxt = '0;
        hi_zero   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            hi_zero      = hi_zero & (scratch[4*k +: 4] == 4'd0);
            blank_nxt[k] = hi_zero;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bin       <= '0;
            scratch   <= '0;
            cnt       <= '0;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.bdc   <= '0;
`ifdef B2BD_BLANK_EN
            bus.blank <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin       <= bus.bc;
                        scratch   <= '0;
                        cnt       <= CW'(BW - 1);
                        state     <= SHIFT;
                        bus.ready <= 1'b0;
                        bus.busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Correct digits, then shift {scratch, bin} left by one.
                    scratch <= {adj[SW-2:0], bin[BW-1]};
                    bin     <= {bin[BW-2:0], 1'b0};
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    bus.bdc   <= scratch;
                    bus.done  <= 1'b1;
                    bus.ready <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
`ifdef B2BD_BLANK_EN
                    bus.blank <= blank_nxt;
`endif
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                    bus.busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
